// File: rtl/nios_loader_pkg.sv
// Shared types and helpers for the on-chip RAM stream loader.
package nios_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_VERIFY,
    S_DONE
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_OVF    = 2'd1;
  localparam logic [1:0] ERR_VERIFY = 2'd2;

  // Lanes 0..lane are populated, so enable that many low byte lanes.
  function automatic logic [3:0] lane_to_be(input logic [1:0] lane);
    logic [3:0] be;
    case (lane)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0011;
      2'd2:    be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
    return mask;
  endfunction

endpackage

// File: rtl/nios_loader_word_packer.sv
// Packs an accepted byte stream little-endian into 32-bit words.
module nios_loader_word_packer
  import nios_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept_en,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        word_valid,
  output logic        word_last,
  output logic [31:0] word,
  output logic [3:0]  be
);

  logic [1:0]  lane;
  logic [31:0] asm_word;
  logic        accepted;

  assign accepted   = accept_en && byte_valid;
  assign word_valid = accepted && (lane == 2'd3 || byte_last);
  assign word_last  = accepted && byte_last;
  // The completing byte is merged combinationally so the word is handed off in its acceptance cycle.
  assign word       = asm_word | (32'(byte_data) << {lane, 3'b000});
  assign be         = lane_to_be(lane);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane     <= 2'd0;
      asm_word <= 32'd0;
    end else if (clear) begin
      lane     <= 2'd0;
      asm_word <= 32'd0;
    end else if (accepted) begin
      if (word_valid) begin
        lane     <= 2'd0;
        asm_word <= 32'd0;
      end else begin
        lane     <= lane + 2'd1;
        asm_word <= word;
      end
    end
  end

endmodule

// File: rtl/nios_system_onchip_mem_loader.sv
// Streams bytes into the 4096x32 on-chip RAM and optionally verifies the loaded region by checksum.
module nios_system_onchip_mem_loader
  import nios_loader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              verify_en,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_written,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  state_t state, state_next;

  logic [ADDR_W:0]   ptr;
  logic [ADDR_W:0]   ptr_eff;
  logic [ADDR_W-1:0] base;
  logic              verify_q;
  logic              wr_valid;
  logic [31:0]       wr_word;
  logic [3:0]        wr_be;
  logic [3:0]        last_be;
  logic [31:0]       checksum;
  logic [ADDR_W:0]   rd_cnt;
  logic              rd_pend;
  logic [31:0]       rd_sum;
  logic [31:0]       rd_masked;
  logic [31:0]       rd_final;
  logic              rd_issue;
  logic              rd_compare;
  logic              start_ok;
  logic              overflow;
  logic              done_q;
  logic [1:0]        err_q;

  logic              word_valid;
  logic              word_last;
  logic [31:0]       word;
  logic [3:0]        word_be;

  assign start_ok = start && (state == S_IDLE || state == S_DONE);

  nios_loader_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .accept_en  (byte_ready),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .word_valid (word_valid),
    .word_last  (word_last),
    .word       (word),
    .be         (word_be)
  );

  // A write still pending this cycle will consume ptr, so overflow is judged against ptr after it.
  assign ptr_eff  = ptr + {{ADDR_W{1'b0}}, wr_valid};
  assign overflow = word_valid && (ptr_eff > LAST_ADDR);

  assign rd_issue   = (state == S_VERIFY) && (rd_cnt < words_written);
  assign rd_compare = (state == S_VERIFY) && (rd_cnt == words_written);
  assign rd_masked  = mem_readdata & (rd_compare ? be_to_mask(last_be) : 32'hFFFF_FFFF);
  assign rd_final   = rd_sum + (rd_pend ? rd_masked : 32'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_next = S_LOAD;
      S_LOAD: begin
        if (overflow)                     state_next = S_DONE;
        else if (word_valid && word_last) state_next = S_FLUSH;
      end
      S_FLUSH:  state_next = verify_q ? S_VERIFY : S_DONE;
      S_VERIFY: if (rd_compare) state_next = S_DONE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr           <= '0;
      base          <= '0;
      verify_q      <= 1'b0;
      wr_valid      <= 1'b0;
      wr_word       <= 32'd0;
      wr_be         <= 4'd0;
      last_be       <= 4'd0;
      checksum      <= 32'd0;
      words_written <= '0;
      rd_cnt        <= '0;
      rd_pend       <= 1'b0;
      rd_sum        <= 32'd0;
      done_q        <= 1'b0;
      err_q         <= ERR_NONE;
    end else if (start_ok) begin
      ptr           <= {1'b0, start_addr};
      base          <= start_addr;
      verify_q      <= verify_en;
      wr_valid      <= 1'b0;
      checksum      <= 32'd0;
      words_written <= '0;
      rd_cnt        <= '0;
      rd_pend       <= 1'b0;
      rd_sum        <= 32'd0;
      done_q        <= 1'b0;
      err_q         <= ERR_NONE;
    end else begin
      wr_valid <= word_valid && !overflow;
      if (word_valid && !overflow) begin
        wr_word <= word;
        wr_be   <= word_be;
      end
      if (wr_valid) begin
        checksum      <= checksum + (wr_word & be_to_mask(wr_be));
        words_written <= words_written + 1'b1;
        ptr           <= ptr + 1'b1;
        last_be       <= wr_be;
      end
      if (state == S_LOAD && overflow) begin
        done_q <= 1'b1;
        err_q  <= ERR_OVF;
      end
      if (state == S_FLUSH && !verify_q) done_q <= 1'b1;
      if (state == S_VERIFY) begin
        rd_pend <= rd_issue;
        rd_sum  <= rd_final;
        if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
        if (rd_compare) begin
          done_q <= 1'b1;
          err_q  <= (rd_final != checksum) ? ERR_VERIFY : ERR_NONE;
        end
      end
    end
  end

  assign byte_ready     = (state == S_LOAD);
  assign busy           = (state == S_LOAD) || (state == S_FLUSH) || (state == S_VERIFY);
  assign done           = done_q;
  assign err_code       = err_q;
  assign mem_clken      = ~reset;
  assign mem_chipselect = wr_valid || rd_issue;
  assign mem_write      = wr_valid;
  assign mem_address    = wr_valid ? ptr[ADDR_W-1:0] :
                          rd_issue ? base + rd_cnt[ADDR_W-1:0] : '0;
  assign mem_byteenable = wr_valid ? wr_be : (rd_issue ? 4'hF : 4'h0);
  assign mem_writedata  = wr_valid ? wr_word : 32'd0;

endmodule

// File: tb/tb_nios_system_onchip_mem_loader.sv
// Directed bench for the RAM loader: RAM model, expectation model and a per-cycle bus checker.
module tb_nios_system_onchip_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] start_addr;
  logic        verify_en;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [12:0] words_written;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;

  int vectors = 0;
  int miscompares = 0;

  int          exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [3:0]  exp_wb[$];
  int          exp_ra[$];
  int          cap_wa[$];
  logic [31:0] cap_wd[$];
  logic [3:0]  cap_wb[$];

  bit          mon_en = 1'b0;
  bit          corrupt_en = 1'b0;
  int          corrupt_addr = 0;

  logic [31:0] ram [0:4095];
  logic [11:0] ram_addr_q;
  bit          filled;

  always #5 clk = ~clk;

  nios_system_onchip_mem_loader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_addr     (start_addr),
    .verify_en      (verify_en),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_last      (byte_last),
    .byte_ready     (byte_ready),
    .busy           (busy),
    .done           (done),
    .err_code       (err_code),
    .words_written  (words_written),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  // Background pattern makes byte-lane masking on partial words observable.
  always @(posedge clk) begin
    logic [31:0] v;
    if (reset && !filled) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 32'hDEAD_BEEF;
      filled <= 1'b1;
    end else if (mem_chipselect && mem_write) begin
      v = ram[mem_address];
      for (int i = 0; i < 4; i++)
        if (mem_byteenable[i]) v[8*i +: 8] = mem_writedata[8*i +: 8];
      if (corrupt_en && int'(mem_address) == corrupt_addr) v[0] = ~v[0];
      ram[mem_address] <= v;
    end
    ram_addr_q <= mem_address;
  end
  assign mem_readdata = ram[ram_addr_q];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_chipselect && mem_write) begin
        cap_wa.push_back(int'(mem_address));
        cap_wd.push_back(mem_writedata);
        cap_wb.push_back(mem_byteenable);
        if (exp_wa.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL write_unexpected: got write to 0x%03h expected none", mem_address);
        end else begin
          check("write_addr", 32'(mem_address), exp_wa.pop_front());
          check("write_data", mem_writedata, exp_wd.pop_front());
          check("write_be", 32'(mem_byteenable), 32'(exp_wb.pop_front()));
        end
      end else if (mem_chipselect) begin
        if (exp_ra.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL read_unexpected: got read of 0x%03h expected none", mem_address);
        end else begin
          check("read_addr", 32'(mem_address), exp_ra.pop_front());
        end
      end else begin
        check("idle_be", 32'(mem_byteenable), 32'd0);
      end
    end
  end

  // Bytes are 1..n; each finished word goes to the next address unless the address has run past the RAM.
  task automatic build_model(input int sa, input int n, input bit ven, input bit cor, input int caddr,
                             output int exp_err, output int exp_words);
    int ptr = sa;
    int lane = 0;
    logic [31:0] w = 0;
    logic [31:0] sum_w = 0;
    logic [31:0] sum_r = 0;
    exp_err = 0;
    exp_words = 0;
    for (int i = 0; i < n; i++) begin
      w = w | (32'(i + 1) << (8 * lane));
      if (lane == 3 || i == n - 1) begin
        if (ptr > 4095) begin
          exp_err = 1;
          break;
        end
        exp_wa.push_back(ptr);
        exp_wd.push_back(w);
        exp_wb.push_back(4'((1 << (lane + 1)) - 1));
        sum_w += w;
        sum_r += w ^ ((cor && ptr == caddr) ? 32'd1 : 32'd0);
        ptr++;
        exp_words++;
        w = 0;
        lane = 0;
      end else begin
        lane++;
      end
    end
    if (exp_err == 0 && ven) begin
      for (int k = 0; k < exp_words; k++) exp_ra.push_back((sa + k) % 4096);
      if (sum_w != sum_r) exp_err = 2;
    end
  endtask

  task automatic applyStimulus(input int sa, input bit ven);
    start = 1'b1;
    start_addr = 12'(sa);
    verify_en = ven;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drive_stream(input int n, input bit with_last, input bit gapped);
    int idx = 0;
    int cyc = 0;
    logic rdy;
    while (idx < n && cyc < 300) begin
      byte_valid = !gapped || (cyc % 4 == 0) || (cyc % 4 == 3);
      byte_data  = 8'(idx + 1);
      byte_last  = with_last && (idx == n - 1);
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk);
      if (byte_valid && rdy) idx++;
      #1;
      cyc++;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    byte_data  = 8'd0;
    if (idx < n) check("stream_accept_timeout", idx, n);
  endtask

  task automatic checkOutput(input int exp_err, input int exp_words);
    int cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    check("err_code", 32'(err_code), exp_err);
    check("words_written", 32'(words_written), exp_words);
    check("byte_ready_done", 32'(byte_ready), 32'd0);
    check("busy_done", 32'(busy), 32'd0);
    check("writes_outstanding", exp_wa.size(), 0);
    check("reads_outstanding", exp_ra.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_scenario(input int sa, input int n, input bit ven, input bit gapped,
                              input bit cor, input int caddr);
    int e_err, e_words;
    cap_wa.delete();
    cap_wd.delete();
    cap_wb.delete();
    corrupt_en = cor;
    corrupt_addr = caddr;
    build_model(sa, n, ven, cor, caddr, e_err, e_words);
    applyStimulus(sa, ven);
    drive_stream(n, 1'b1, gapped);
    checkOutput(e_err, e_words);
    corrupt_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start_addr = 12'd0;
    verify_en = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'd0;
    byte_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_clken", 32'(mem_clken), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("clken_after_reset", 32'(mem_clken), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] full words with verify");
    run_scenario(32'h010, 8, 1'b1, 1'b0, 1'b0, 0);
    check("s1_wd0", cap_wd[0], 32'h0403_0201);
    check("s1_wa1", cap_wa[1], 32'h011);
    check("s1_wd1", cap_wd[1], 32'h0807_0605);

    $display("[TB] partial last word");
    run_scenario(32'h100, 5, 1'b1, 1'b0, 1'b0, 0);
    check("s2_wd1", cap_wd[1], 32'h0000_0005);
    check("s2_wb1", 32'(cap_wb[1]), 32'h1);

    $display("[TB] overflow at top of RAM");
    run_scenario(32'hFFF, 8, 1'b1, 1'b0, 1'b0, 0);
    check("s3_nwrites", cap_wa.size(), 1);
    check("s3_wa0", cap_wa[0], 32'hFFF);
    check("s3_err", 32'(err_code), 32'd1);

    $display("[TB] verify mismatch");
    run_scenario(32'h010, 8, 1'b1, 1'b0, 1'b1, 32'h011);
    check("s4_err", 32'(err_code), 32'd2);

    $display("[TB] gapped stream");
    run_scenario(32'h010, 8, 1'b1, 1'b1, 1'b0, 0);
    check("s5_wd1", cap_wd[1], 32'h0807_0605);

    $display("[TB] reset mid-load");
    applyStimulus(32'h020, 1'b0);
    drive_stream(3, 1'b0, 1'b0);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(byte_ready), 32'd0);
    check("mid_rst_cs", 32'(mem_chipselect), 32'd0);
    check("mid_rst_write", 32'(mem_write), 32'd0);
    check("mid_rst_be", 32'(mem_byteenable), 32'd0);
    check("mid_rst_clken", 32'(mem_clken), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_wa.delete();
    exp_wd.delete();
    exp_wb.delete();
    exp_ra.delete();
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    run_scenario(32'h040, 4, 1'b0, 1'b0, 1'b0, 0);
    check("s6_wa0", cap_wa[0], 32'h040);
    check("s6_wd0", cap_wd[0], 32'h0403_0201);
    check("s6_wb0", 32'(cap_wb[0]), 32'hF);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
